// File: rtl/sdrc_port_arbiter_pkg.sv
// Shared types and default widths for the two-port SDRC arbiter.
// Imported by the interface, the picker and the arbiter top.
package sdrc_port_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF = 21;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned LEN_W_DEF  = 8;
   localparam int unsigned TMO_DEF    = 1024;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWrBurst,
      StRdBurst,
      StRelease
   } arb_state_e;

   typedef logic port_idx_t;

   function automatic logic [1:0] port_onehot(port_idx_t p);
      return p ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sdrc_port_arbiter_if.sv
// One requester port of the SDRC arbiter: command request, write stream and read return.
// The arbiter takes the slave view; a requester takes the master view.
interface sdrc_port_arbiter_if
   import sdrc_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned LEN_W  = LEN_W_DEF
);
   localparam int unsigned DQM_W = DATA_W / 8;

   logic              req;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  len;
   logic [DATA_W-1:0] wdata;
   logic [DQM_W-1:0]  dqm;
   logic              grant;
   logic              wbeat;
   logic              rvalid;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, wr, addr, len, wdata, dqm,
      input  grant, wbeat, rvalid, done, err, rdata
   );

   modport slave (
      input  req, wr, addr, len, wdata, dqm,
      output grant, wbeat, rvalid, done, err, rdata
   );

endinterface

// File: rtl/sdrc_port_arbiter_rr_pick.sv
// Two-way round-robin picker; a tie goes to the port that did not own the SDRC last.
// Purely combinational, the last-owner register lives in the arbiter.
module sdrc_port_arbiter_rr_pick
   import sdrc_port_arbiter_pkg::*;
(
   input  logic      req0_i,
   input  logic      req1_i,
   input  port_idx_t rr_last_i,
   output logic      any_o,
   output port_idx_t owner_o
);

   always_comb begin
      any_o   = req0_i | req1_i;
      owner_o = req1_i;
      if (req0_i && req1_i) begin
         owner_o = ~rr_last_i;
      end
   end

endmodule

// File: rtl/sdrc_port_arbiter.sv
// Two-port round-robin arbiter in front of one SDRC user interface.
// The owner keeps the SDRC from command issue until its burst completes or the watchdog fires.
module sdrc_port_arbiter
   import sdrc_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned LEN_W  = LEN_W_DEF,
   parameter int unsigned TMO    = TMO_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sdrc_port_arbiter_if.slave    p0,
   sdrc_port_arbiter_if.slave    p1,
   input  logic                  sdrc_init_done,
   input  logic                  sdrc_busy_n,
   input  logic                  sdrc_rd_valid,
   input  logic [DATA_W-1:0]     sdrc_data_out,
   output logic                  sdrc_wr_n,
   output logic                  sdrc_rd_n,
   output logic [ADDR_W-1:0]     sdrc_addr,
   output logic [LEN_W-1:0]      sdrc_data_len,
   output logic [DATA_W-1:0]     sdrc_data,
   output logic [DATA_W/8-1:0]   sdrc_dqm
);

   localparam int unsigned WD_W   = $clog2(TMO + 1);
   localparam int unsigned BEAT_W = LEN_W + 1;

   arb_state_e        state_q, state_d;
   port_idx_t         owner_q, owner_d, rr_last_q, rr_last_d, pick_owner;
   logic              pick_any;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              wr_n_q, wr_n_d, rd_n_q, rd_n_d;
   logic [1:0]        grant_q, grant_d, wbeat_q, wbeat_d, done_q, done_d, err_q, err_d;
   logic              timeout, fin, issue_nx, wbeat_nx, last_beat, rd_route, wr_own;

   sdrc_port_arbiter_rr_pick u_pick (
      .req0_i    (p0.req),
      .req1_i    (p1.req),
      .rr_last_i (rr_last_q),
      .any_o     (pick_any),
      .owner_o   (pick_owner)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_last_d = rr_last_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      len_d     = len_q;
      beat_d    = beat_q;
      fin       = 1'b0;
      last_beat = (beat_q == {1'b0, len_q});
      // Watchdog age is zero in ISSUE, so expiry lands exactly TMO cycles after the grant.
      wd_d      = (state_q == StIdle) ? '0 : wd_q + WD_W'(1);
      timeout   = (state_q inside {StWrBurst, StRdBurst, StRelease}) &&
                  (wd_q == WD_W'(TMO - 1));

      unique case (state_q)
         StIdle: begin
            if (sdrc_init_done && sdrc_busy_n && pick_any) begin
               owner_d = pick_owner;
               wr_d    = pick_owner ? p1.wr   : p0.wr;
               addr_d  = pick_owner ? p1.addr : p0.addr;
               len_d   = pick_owner ? p1.len  : p0.len;
               state_d = StIssue;
            end
         end
         StIssue: begin
            rr_last_d = owner_q;
            beat_d    = '0;
            if (wr_q) begin
               // Beat 0 is consumed alongside the command strobe.
               beat_d  = BEAT_W'(1);
               state_d = (len_q == '0) ? StRelease : StWrBurst;
            end else begin
               state_d = StRdBurst;
            end
         end
         StWrBurst: begin
            beat_d = beat_q + BEAT_W'(1);
            if (last_beat) state_d = StRelease;
         end
         StRdBurst: begin
            if (sdrc_rd_valid) begin
               beat_d = beat_q + BEAT_W'(1);
               if (last_beat) state_d = StRelease;
            end
         end
         StRelease: begin
            if (sdrc_busy_n) begin
               fin     = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (timeout) begin
         fin     = 1'b1;
         state_d = StIdle;
      end

      // Output flops are loaded with the values belonging to the next state.
      issue_nx = (state_d == StIssue);
      wbeat_nx = (issue_nx && wr_d) || (state_d == StWrBurst);
      wr_n_d   = ~(issue_nx && wr_d);
      rd_n_d   = ~(issue_nx && !wr_d);
      grant_d  = issue_nx ? port_onehot(owner_d) : 2'b00;
      wbeat_d  = wbeat_nx ? port_onehot(owner_d) : 2'b00;
      done_d   = fin ? port_onehot(owner_q) : 2'b00;
      err_d    = (fin && timeout) ? port_onehot(owner_q) : 2'b00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         owner_q   <= 1'b0;
         rr_last_q <= 1'b1;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         wd_q      <= '0;
         wr_n_q    <= 1'b1;
         rd_n_q    <= 1'b1;
         grant_q   <= 2'b00;
         wbeat_q   <= 2'b00;
         done_q    <= 2'b00;
         err_q     <= 2'b00;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_last_q <= rr_last_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         wd_q      <= wd_d;
         wr_n_q    <= wr_n_d;
         rd_n_q    <= rd_n_d;
         grant_q   <= grant_d;
         wbeat_q   <= wbeat_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign rd_route = (state_q == StRdBurst) && sdrc_rd_valid;
   assign wr_own   = wr_q && (state_q inside {StIssue, StWrBurst});

   assign sdrc_wr_n     = wr_n_q;
   assign sdrc_rd_n     = rd_n_q;
   assign sdrc_addr     = addr_q;
   assign sdrc_data_len = len_q;
   assign sdrc_data     = owner_q ? p1.wdata : p0.wdata;
   assign sdrc_dqm      = wr_own ? (owner_q ? p1.dqm : p0.dqm) : '1;

   assign p0.grant  = grant_q[0];
   assign p1.grant  = grant_q[1];
   assign p0.wbeat  = wbeat_q[0];
   assign p1.wbeat  = wbeat_q[1];
   assign p0.done   = done_q[0];
   assign p1.done   = done_q[1];
   assign p0.err    = err_q[0];
   assign p1.err    = err_q[1];
   assign p0.rvalid = rd_route && (owner_q == 1'b0);
   assign p1.rvalid = rd_route && (owner_q == 1'b1);
   assign p0.rdata  = sdrc_data_out;
   assign p1.rdata  = sdrc_data_out;

endmodule
